// File: rtl/ov7670_stream_emulator.sv
// OV7670-style byte stream transmitter: reads RGB565 pixels from a 1-cycle sync RAM
// and emits v_sync/href/data with parameterised line and frame timing.
module ov7670_stream_emulator #(
    parameter int H_ACTIVE      = 320,
    parameter int V_ACTIVE      = 240,
    parameter int H_BLANK       = 144,
    parameter int VSYNC_LINES   = 3,
    parameter int V_BACK_LINES  = 17,
    parameter int V_FRONT_LINES = 10,
    parameter int ADDR_W        = 17
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              enable,
    output logic              rEn,
    output logic [ADDR_W-1:0] rAddr,
    input  logic [15:0]       rData,
    output logic              v_sync,
    output logic              href,
    output logic [7:0]        ov7670_data,
    output logic              frame_done
);

    localparam int LINE_LEN  = 2 * H_ACTIVE + H_BLANK;
    localparam int H_W       = $clog2(LINE_LEN);
    localparam int MAX_AB    = (V_ACTIVE > V_BACK_LINES) ? V_ACTIVE : V_BACK_LINES;
    localparam int MAX_SF    = (VSYNC_LINES > V_FRONT_LINES) ? VSYNC_LINES : V_FRONT_LINES;
    localparam int MAX_LINES = (MAX_AB > MAX_SF) ? MAX_AB : MAX_SF;
    localparam int L_W       = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;

    localparam bit NO_BACK  = (V_BACK_LINES == 0);
    localparam bit NO_FRONT = (V_FRONT_LINES == 0);
    localparam bit HAS_MID  = (H_ACTIVE > 1);

    localparam logic [H_W-1:0] H_LAST    = H_W'(LINE_LEN - 1);
    localparam logic [H_W-1:0] H_PRE     = H_W'(LINE_LEN - 2);
    localparam logic [H_W-1:0] H_ACT_END = H_W'(2 * H_ACTIVE);
    localparam logic [H_W-1:0] H_RD_LAST = H_W'(HAS_MID ? 2 * H_ACTIVE - 4 : 0);

    localparam logic [L_W-1:0] VS_LAST = L_W'((VSYNC_LINES > 0) ? VSYNC_LINES - 1 : 0);
    localparam logic [L_W-1:0] VB_LAST = L_W'(NO_BACK ? 0 : V_BACK_LINES - 1);
    localparam logic [L_W-1:0] VA_LAST = L_W'(V_ACTIVE - 1);
    localparam logic [L_W-1:0] VF_LAST = L_W'(NO_FRONT ? 0 : V_FRONT_LINES - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_VSYNC   = 3'd1;
    localparam logic [2:0] S_V_BACK  = 3'd2;
    localparam logic [2:0] S_ACTIVE  = 3'd3;
    localparam logic [2:0] S_V_FRONT = 3'd4;

    localparam logic [2:0]     LAST_STATE = NO_FRONT ? S_ACTIVE : S_V_FRONT;
    localparam logic [L_W-1:0] LAST_LN    = NO_FRONT ? VA_LAST : VF_LAST;

    // Position counters describe the cycle currently on the outputs.
    logic [2:0]        st, st_n;
    logic [H_W-1:0]    h, h_n;
    logic [L_W-1:0]    ln, ln_n;
    logic              ln_last;
    logic [2:0]        frame_next;
    logic [15:0]       pix_hold;
    logic              rd_pend;
    logic [ADDR_W-1:0] rd_next;

    logic              href_n, vsync_n, fd_n, ren_n, pix_rd, first_rd, frame_start;
    logic [7:0]        data_n;

    always_comb begin
        case (st)
            S_VSYNC:   ln_last = (ln == VS_LAST);
            S_V_BACK:  ln_last = (ln == VB_LAST);
            S_ACTIVE:  ln_last = (ln == VA_LAST);
            S_V_FRONT: ln_last = (ln == VF_LAST);
            default:   ln_last = 1'b0;
        endcase
    end

    assign frame_next = enable ? S_VSYNC : S_IDLE;

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        st_n = st;
        h_n  = h;
        ln_n = ln;
        if (st == S_IDLE) begin
            if (enable) begin
                st_n = S_VSYNC;
                h_n  = '0;
                ln_n = '0;
            end
        end else if (h != H_LAST) begin
            h_n = h + 1'b1;
        end else begin
            h_n = '0;
            if (!ln_last) begin
                ln_n = ln + 1'b1;
            end else begin
                ln_n = '0;
                case (st)
                    S_VSYNC:  st_n = NO_BACK ? S_ACTIVE : S_V_BACK;
                    S_V_BACK: st_n = S_ACTIVE;
                    S_ACTIVE: st_n = NO_FRONT ? frame_next : S_V_FRONT;
                    default:  st_n = frame_next;
                endcase
            end
        end
    end

    // Outputs are derived from the next position and registered alongside it.
    always_comb begin
        vsync_n     = (st_n == S_VSYNC);
        href_n      = (st_n == S_ACTIVE) && (h_n < H_ACT_END);
        fd_n        = (st_n == LAST_STATE) && (ln_n == LAST_LN) && (h_n == H_LAST);
        frame_start = (st_n == S_VSYNC) && (ln_n == '0) && (h_n == '0);
        // Pixels 1.. of a line are fetched two cycles ahead of their high byte;
        // pixel 0 is fetched from the tail of the preceding line's blanking.
        pix_rd      = HAS_MID && (st_n == S_ACTIVE) && !h_n[0] && (h_n <= H_RD_LAST);
        first_rd    = (h_n == H_PRE) &&
                      (((st_n == S_ACTIVE) && (ln_n != VA_LAST)) ||
                       ((st_n == S_V_BACK) && (ln_n == VB_LAST)) ||
                       (NO_BACK && (st_n == S_VSYNC) && (ln_n == VS_LAST)));
        ren_n       = pix_rd || first_rd;
        data_n      = 8'h00;
        if (href_n) begin
            data_n = h_n[0] ? pix_hold[7:0] : rData[15:8];
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            st          <= S_IDLE;
            h           <= '0;
            ln          <= '0;
            v_sync      <= 1'b0;
            href        <= 1'b0;
            ov7670_data <= 8'h00;
            frame_done  <= 1'b0;
            rEn         <= 1'b0;
            rAddr       <= '0;
            rd_next     <= '0;
            rd_pend     <= 1'b0;
            pix_hold    <= 16'h0000;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            st          <= st_n;
            h           <= h_n;
            ln          <= ln_n;
            v_sync      <= vsync_n;
            href        <= href_n;
            ov7670_data <= data_n;
            frame_done  <= fd_n;
            rEn         <= ren_n;
            rd_pend     <= rEn;
            if (rd_pend) begin
                pix_hold <= rData;
            end
            if (ren_n) begin
                rAddr   <= rd_next;
                rd_next <= rd_next + 1'b1;
            end else if (frame_start) begin
                rd_next <= '0;
            end
        end
    end

endmodule
